// File: rtl/led_pkg.sv
// Shared types and constants for the HUB75 64x64 scan driver.
package led_pkg;

    typedef enum logic [1:0] {
        SHIFT,
        BLANK,
        LATCH,
        HOLD
    } led_state_t;

    localparam int PANEL_W   = 64;
    localparam int SCAN_ROWS = 32;
    localparam int PHASES    = 4;

    localparam logic [1:0] PH_TOP  = 2'd0;
    localparam logic [1:0] PH_BOT  = 2'd1;
    localparam logic [1:0] PH_DATA = 2'd2;
    localparam logic [1:0] PH_CLK  = 2'd3;

    // Bit positions of each pin group inside the LED_PANEL output vector.
    localparam int PIN_RGB0     = 0;
    localparam int PIN_RGB1     = 3;
    localparam int PIN_ROW_ADDR = 6;
    localparam int PIN_SCLK     = 11;
    localparam int PIN_LATCH    = 12;
    localparam int PIN_BLANK    = 13;
    localparam int LED_PANEL_W  = 14;

    localparam logic [LED_PANEL_W-1:0] PANEL_IDLE = LED_PANEL_W'(1 << PIN_BLANK);

endpackage

// File: rtl/led_pwm_compare.sv
// Threshold PWM: each colour channel is lit when it exceeds the current subframe.
module led_pwm_compare (
    input  logic [23:0] rgb24,
    input  logic [7:0]  threshold,
    output logic [2:0]  bgr
);

    assign bgr = {rgb24[7:0] > threshold, rgb24[15:8] > threshold, rgb24[23:16] > threshold};

endmodule

// File: rtl/led_scan_driver.sv
// HUB75 1/32-scan driver: requests pixels from a painter24 source, shifts
// two half-panel rows per pass, then latches, addresses and unblanks the row.
module led_scan_driver
    import led_pkg::*;
#(
    parameter int FRAME_BITS = 13,
    parameter int DELAY      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [FRAME_BITS-1:0] frame,
    output logic [7:0]            subframe,
    output logic [5:0]            x,
    output logic [5:0]            y,
    input  logic [23:0]           rgb24,
    output logic [2:0]            rgb0,
    output logic [2:0]            rgb1,
    output logic [4:0]            row_addr,
    output logic                  sclk,
    output logic                  latch,
    output logic                  blank
);

    localparam int HOLD_W = (DELAY > 1) ? $clog2(DELAY) : 1;

    led_state_t              state, state_n;
    logic [5:0]              col, col_n;
    logic [1:0]              phase, phase_n;
    logic [4:0]              row, row_n;
    logic [HOLD_W-1:0]       hold_cnt, hold_n;
    logic [FRAME_BITS-1:0]   frame_q, frame_n;
    logic [7:0]              subframe_q, subframe_n;
    logic [5:0]              x_q, x_n;
    logic [5:0]              y_q, y_n;
    logic [LED_PANEL_W-1:0]  panel_q, panel_n;
    logic [23:0]             top_q;
    logic [2:0]              bgr_top, bgr_bot;

    led_pwm_compare u_pwm_top (
        .rgb24     (top_q),
        .threshold (subframe_q),
        .bgr       (bgr_top)
    );

    // The bottom pixel is still on rgb24 when the column's data is committed.
    led_pwm_compare u_pwm_bot (
        .rgb24     (rgb24),
        .threshold (subframe_q),
        .bgr       (bgr_bot)
    );

    always_comb begin
        state_n    = state;
        col_n      = col;
        phase_n    = phase;
        row_n      = row;
        hold_n     = hold_cnt;
        frame_n    = frame_q;
        subframe_n = subframe_q;

        case (state)
            SHIFT: begin
                phase_n = phase + 2'd1;
                if (phase == 2'(PHASES - 1)) begin
                    col_n = col + 6'd1;
                    if (col == 6'(PANEL_W - 1)) state_n = BLANK;
                end
            end
            BLANK: state_n = LATCH;
            LATCH: begin
                state_n = HOLD;
                hold_n  = '0;
            end
            HOLD: begin
                hold_n = hold_cnt + 1'b1;
                if (hold_cnt == HOLD_W'(DELAY - 1)) begin
                    state_n = SHIFT;
                    col_n   = '0;
                    phase_n = PH_TOP;
                    row_n   = row + 5'd1;
                    if (row == 5'(SCAN_ROWS - 1)) begin
                        subframe_n = subframe_q + 8'd1;
                        if (subframe_q == 8'hFF) frame_n = frame_q + 1'b1;
                    end
                end
            end
            default: state_n = SHIFT;
        endcase

        // Outputs are decoded from the next state so they line up with it.
        panel_n            = panel_q;
        panel_n[PIN_SCLK]  = 1'b0;
        panel_n[PIN_LATCH] = 1'b0;
        x_n                = x_q;
        y_n                = y_q;

        case (state_n)
            SHIFT: begin
                if (phase_n == PH_TOP) begin
                    x_n = col_n;
                    y_n = {1'b0, row_n};
                end
                if (phase_n == PH_BOT) begin
                    x_n = col_n;
                    y_n = {1'b1, row_n};
                end
                if (phase_n == PH_CLK) panel_n[PIN_SCLK] = 1'b1;
            end
            BLANK: begin
                panel_n[PIN_BLANK]          = 1'b1;
                panel_n[PIN_ROW_ADDR +: 5]  = row_n;
            end
            LATCH: begin
                panel_n[PIN_LATCH] = 1'b1;
                panel_n[PIN_BLANK] = 1'b1;
            end
            HOLD:    panel_n[PIN_BLANK] = 1'b0;
            default: ;
        endcase

        if (state == SHIFT && phase == PH_BOT) begin
            panel_n[PIN_RGB0 +: 3] = bgr_top;
            panel_n[PIN_RGB1 +: 3] = bgr_bot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SHIFT;
            col        <= '0;
            phase      <= PH_TOP;
            row        <= '0;
            hold_cnt   <= '0;
            frame_q    <= '0;
            subframe_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            panel_q    <= PANEL_IDLE;
        end else begin
            state      <= state_n;
            col        <= col_n;
            phase      <= phase_n;
            row        <= row_n;
            hold_cnt   <= hold_n;
            frame_q    <= frame_n;
            subframe_q <= subframe_n;
            x_q        <= x_n;
            y_q        <= y_n;
            panel_q    <= panel_n;
        end
    end

    always_ff @(posedge clk) begin
        if (state == SHIFT && phase == PH_TOP) top_q <= rgb24;
    end

    assign frame    = frame_q;
    assign subframe = subframe_q;
    assign x        = x_q;
    assign y        = y_q;
    assign rgb0     = panel_q[PIN_RGB0 +: 3];
    assign rgb1     = panel_q[PIN_RGB1 +: 3];
    assign row_addr = panel_q[PIN_ROW_ADDR +: 5];
    assign sclk     = panel_q[PIN_SCLK];
    assign latch    = panel_q[PIN_LATCH];
    assign blank    = panel_q[PIN_BLANK];

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver: timing of the row cycle, PWM data and counter wraps.
module tb_led_scan_driver;

    logic        clk;
    logic        reset;
    logic [12:0] frame;
    logic [7:0]  subframe;
    logic [5:0]  x;
    logic [5:0]  y;
    logic [23:0] rgb24;
    logic [2:0]  rgb0;
    logic [2:0]  rgb1;
    logic [4:0]  row_addr;
    logic        sclk;
    logic        latch;
    logic        blank;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode   = 0;

    localparam int ROW_T = 259;

    led_scan_driver #(.FRAME_BITS(13), .DELAY(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .frame    (frame),
        .subframe (subframe),
        .x        (x),
        .y        (y),
        .rgb24    (rgb24),
        .rgb0     (rgb0),
        .rgb1     (rgb1),
        .row_addr (row_addr),
        .sclk     (sclk),
        .latch    (latch),
        .blank    (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Painter model: colour depends only on the requested pixel and the test mode.
    always_comb begin
        rgb24 = 24'h0;
        case (mode)
            1: rgb24 = 24'h800000;
            2: if (x == 6'd5 && y == 6'd37) rgb24 = 24'hC80000;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        reset = 1'b1;

        // Reset state and first row timing
        do_reset();
        check("rst_blank", blank, 1);
        check("rst_latch", latch, 0);
        check("rst_sclk", sclk, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_rgb0", rgb0, 0);
        check("rst_frame", frame, 0);
        check("rst_sub", subframe, 0);
        tick();
        check("c1_y_bottom", y, 32);
        tick();
        check("c2_sclk", sclk, 0);
        tick();
        check("c3_sclk", sclk, 1);
        run_to(256);
        check("c256_blank", blank, 1);
        check("c256_latch", latch, 0);
        run_to(257);
        check("c257_latch", latch, 1);
        check("c257_blank", blank, 1);
        run_to(258);
        check("c258_blank", blank, 0);
        check("c258_latch", latch, 0);
        run_to(259);
        check("c259_y", y, 1);
        check("c259_x", x, 0);

        // Reset in the middle of row 1, column 40 phase 3
        run_to(ROW_T + 163);
        check("mid_sclk_pre", sclk, 1);
        check("mid_x_pre", x, 40);
        check("mid_blank_pre", blank, 0);
        reset = 1'b1;
        tick();
        check("mid_sclk", sclk, 0);
        check("mid_blank", blank, 1);
        check("mid_x", x, 0);
        check("mid_y", y, 0);
        reset = 1'b0;
        cyc   = 0;
        mode  = 2;
        run_to(3);
        check("re_c3_sclk", sclk, 1);
        run_to(257);
        check("re_c257_latch", latch, 1);
        run_to(258);
        check("re_c258_blank", blank, 0);

        // Single lit pixel at (5,37): row 5, column 5, lower half
        run_to(5 * ROW_T + 4 * 4 + 3);
        check("px_c4_rgb1", rgb1, 3'b000);
        run_to(5 * ROW_T + 4 * 5 + 3);
        check("px_c5_rgb1", rgb1, 3'b001);
        check("px_c5_rgb0", rgb0, 3'b000);
        run_to(5 * ROW_T + 4 * 6 + 3);
        check("px_c6_rgb1", rgb1, 3'b000);
        run_to(5 * ROW_T + 257);
        check("px_latch", latch, 1);
        check("px_row_addr", row_addr, 5);

        // Constant red 0x80 against threshold 0x7F and 0x80
        do_reset();
        mode = 1;
        force dut.subframe_q = 8'h7F;
        tick();
        release dut.subframe_q;
        run_to(3);
        check("r7f_c0_rgb0", rgb0, 3'b001);
        check("r7f_c0_rgb1", rgb1, 3'b001);
        run_to(4 * 31 + 3);
        check("r7f_c31_rgb0", rgb0, 3'b001);
        check("r7f_c31_rgb1", rgb1, 3'b001);
        run_to(4 * 63 + 3);
        check("r7f_c63_rgb0", rgb0, 3'b001);
        check("r7f_c63_rgb1", rgb1, 3'b001);
        check("r7f_sub", subframe, 8'h7F);
        do_reset();
        force dut.subframe_q = 8'h80;
        tick();
        release dut.subframe_q;
        run_to(3);
        check("r80_c0_rgb0", rgb0, 3'b000);
        check("r80_c0_rgb1", rgb1, 3'b000);
        run_to(4 * 63 + 3);
        check("r80_c63_rgb0", rgb0, 3'b000);
        check("r80_c63_rgb1", rgb1, 3'b000);

        // 32 rows: row address sequence and one subframe step
        do_reset();
        mode = 0;
        for (int r = 0; r < 32; r++) begin
            run_to(r * ROW_T + 257);
            check($sformatf("row%0d_addr", r), row_addr, r);
        end
        check("row31_sub", subframe, 0);
        run_to(32 * ROW_T);
        check("wrap_sub", subframe, 1);
        check("wrap_frame", frame, 0);
        check("wrap_y", y, 0);

        // Subframe and frame wrap at the end of row 31
        run_to(63 * ROW_T + 10);
        force dut.subframe_q = 8'hFF;
        force dut.frame_q    = 13'h1FFF;
        tick();
        release dut.subframe_q;
        release dut.frame_q;
        run_to(63 * ROW_T + 257);
        check("max_sub", subframe, 8'hFF);
        check("max_frame", frame, 13'h1FFF);
        check("max_row_addr", row_addr, 31);
        run_to(64 * ROW_T);
        check("fwrap_sub", subframe, 0);
        check("fwrap_frame", frame, 0);
        check("fwrap_y", y, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
